// File: rtl/mfp_ahb_master_bridge_pkg.sv
// -----------------------------------------------------------------------------
// mfp_ahb_master_bridge_pkg
//   Shared AHB-lite encodings, FSM state type and request legality check used by
//   the mfp_ahb_master_bridge initiator.
//   No ports (package).
// -----------------------------------------------------------------------------
package mfp_ahb_master_bridge_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HSIZE_BYTE    = 3'd0;
   localparam logic [2:0] HSIZE_HALF    = 3'd1;
   localparam logic [2:0] HSIZE_WORD    = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_ERR2
   } state_t;

   // A request may go on the bus only if its size is byte/half/word and the
   // address is naturally aligned to that size.
   function automatic logic req_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
      logic ok;
      ok = 1'b0;
      case (size)
         HSIZE_BYTE: ok = 1'b1;
         HSIZE_HALF: ok = ~addr_lsb[0];
         HSIZE_WORD: ok = (addr_lsb == 2'b00);
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mfp_ahb_master_bridge.sv
// -----------------------------------------------------------------------------
// mfp_ahb_master_bridge
//   Single-outstanding AHB-lite initiator. Turns a valid/ready request into one
//   non-burst AHB-lite transfer and returns exactly one response strobe per
//   accepted request. Handles wait states, the two-cycle ERROR response,
//   misaligned/illegal requests (rejected without a bus transfer) and a
//   data-phase hang timeout.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_addr/req_write/req_size/req_wdata  request payload
//   rsp_valid            one-cycle response strobe
//   rsp_rdata/rsp_err/rsp_timeout  response fields, held until next response
//   HADDR..HWRITE        registered AHB-lite master outputs
//   HRDATA/HREADY/HRESP  AHB-lite slave-side inputs
// -----------------------------------------------------------------------------
module mfp_ahb_master_bridge #(
   parameter int         TIMEOUT_CYCLES = 256,
   parameter logic [3:0] HPROT_VAL      = 4'b0011
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_write,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic [31:0] HADDR,
   output logic [2:0]  HBURST,
   output logic        HMASTLOCK,
   output logic [3:0]  HPROT,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);
   import mfp_ahb_master_bridge_pkg::*;

   localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [31:0]        wdata_q;

   logic [1:0]         htrans_d;
   logic [31:0]        haddr_d;
   logic [2:0]         hsize_d;
   logic               hwrite_d;
   logic [31:0]        hwdata_d;
   logic               rsp_valid_d;
   logic [31:0]        rsp_rdata_d;
   logic               rsp_err_d;
   logic               rsp_timeout_d;

   assign HBURST    = HBURST_SINGLE;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = HPROT_VAL;
   assign req_ready = (state == ST_IDLE);

   // Write data is only consumed after acceptance, so it needs no reset.
   always_ff @(posedge HCLK) begin
      if (state == ST_IDLE && req_valid) begin
         wdata_q <= req_wdata;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         HTRANS      <= HTRANS_IDLE;
         HADDR       <= '0;
         HSIZE       <= '0;
         HWRITE      <= 1'b0;
         HWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         HTRANS      <= htrans_d;
         HADDR       <= haddr_d;
         HSIZE       <= hsize_d;
         HWRITE      <= hwrite_d;
         HWDATA      <= hwdata_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_err     <= rsp_err_d;
         rsp_timeout <= rsp_timeout_d;
      end
   end

   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      htrans_d      = HTRANS;
      haddr_d       = HADDR;
      hsize_d       = HSIZE;
      hwrite_d      = HWRITE;
      hwdata_d      = HWDATA;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;

      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_legal(req_size, req_addr[1:0])) begin
                  state_d  = ST_ADDR;
                  cnt_d    = '0;
                  htrans_d = HTRANS_NONSEQ;
                  haddr_d  = req_addr;
                  hsize_d  = req_size;
                  hwrite_d = req_write;
               end else begin
                  // Rejected locally: answer next cycle, bus untouched.
                  rsp_valid_d   = 1'b1;
                  rsp_rdata_d   = '0;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
               end
            end
         end

         ST_ADDR: begin
            if (HREADY) begin
               state_d  = ST_DATA;
               htrans_d = HTRANS_IDLE;
               hwdata_d = HWRITE ? wdata_q : 32'h0;
            end
         end

         ST_DATA, ST_ERR2: begin
            if (!HREADY) begin
               // Timeout wins over an ERROR first cycle landing on the last count.
               if (cnt == CNT_LAST) begin
                  state_d       = ST_IDLE;
                  rsp_valid_d   = 1'b1;
                  rsp_rdata_d   = '0;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt + 1'b1;
                  if (state == ST_DATA && HRESP) begin
                     state_d = ST_ERR2;
                  end
               end
            end else begin
               state_d       = ST_IDLE;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b0;
               // HREADY with HRESP in DATA is a one-cycle ERROR (protocol
               // violation); still reported as an error completion.
               if (state == ST_ERR2 || HRESP) begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = HWRITE ? 32'h0 : HRDATA;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: doc/mfp_ahb_master_bridge.md
Name: mfp_ahb_master_bridge

Overview:
- Single-outstanding AHB-lite initiator that converts a simple valid/ready request port into single (non-burst) AHB-lite read and write transfers.
- Sits on the master side of the mfp_ahb interconnect, either as a second bus master behind an arbiter or as a debug/DMA front end.
- Handles slave wait states, the two-cycle ERROR response, misaligned requests and a bus-hang timeout.
- Returns one response pulse per accepted request.

Parameters:
- TIMEOUT_CYCLES, 256: maximum data-phase cycles with HREADY=0 before the transfer is abandoned. Legal range 2..65535.
- HPROT_VAL, 4'b0011: constant value driven on HPROT (data access, privileged).

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_addr  in  32  byte address.
- req_write  in  1  1 = write, 0 = read.
- req_size  in  3  HSIZE encoding; 0 = byte, 1 = half, 2 = word, anything else is illegal.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  slave ERROR, misalignment, illegal size or timeout.
- rsp_timeout  out  1  error was caused by timeout; valid with rsp_valid.
- HADDR  out  32  AHB address.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HPROT  out  4  constant HPROT_VAL.
- HSIZE  out  3  transfer size.
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- HWDATA  out  32  write data, driven during the data phase.
- HWRITE  out  1  transfer direction.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer-done / wait-state indication.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Clocking: one clock, HCLK; reset is asynchronous and active-low (HRESETn).
- Reset values: HTRANS=IDLE, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, req_ready=1, state=IDLE, wait counter=0.
- Registered outputs: all AHB outputs are registered; req_ready is a combinational decode of state (high only in IDLE).
- FSM states: IDLE, ADDR, DATA, ERR2.
- IDLE, acceptance: on an edge with req_valid=1, check the request.
  - Legal request: latch addr, size, write and wdata; go to ADDR.
  - Illegal request (size>2, size=1 with addr[0]=1, or size=2 with addr[1:0]!=0): no bus transfer. Next cycle rsp_valid=1, rsp_err=1, rsp_timeout=0; stay in IDLE.
- ADDR: drive HTRANS=NONSEQ plus HADDR, HSIZE and HWRITE.
  - Edge with HREADY=1: go to DATA; HTRANS returns to IDLE.
  - HREADY=0: hold all address-phase outputs.
- DATA: HWDATA holds the latched wdata (writes only; 0 for reads). The wait counter increments on every edge with HREADY=0.
  - HREADY=1, HRESP=0: transfer completes. Capture HRDATA into rsp_rdata for reads. Next cycle rsp_valid=1, rsp_err=0. Go to IDLE.
  - HREADY=0, HRESP=1: first ERROR cycle; go to ERR2.
  - HREADY=1, HRESP=1 (protocol violation): treat as an error completion.
  - Wait counter reaches TIMEOUT_CYCLES-1 with HREADY still 0: abandon the transfer. Respond with rsp_err=1, rsp_timeout=1; go to IDLE. The bus is left as-is; recovery is software's responsibility.
- ERR2: on HREADY=1, respond with rsp_err=1 and rsp_rdata=0; go to IDLE. The timeout counter continues to run in ERR2.
- Response timing: rsp_valid is high for exactly one cycle. rsp_* fields hold their values until the next response. req_ready is high in that same cycle, so back-to-back requests are allowed.
- Latency with a zero-wait slave: acceptance edge T0 → ADDR cycle → DATA cycle → rsp_valid in the 3rd cycle after T0. Minimum request spacing is 3 cycles.
- Reset mid-transfer: every output returns to its reset value immediately, and no response is issued for the aborted request.
- Wait counter: width is clog2(TIMEOUT_CYCLES); it is cleared on entry to ADDR.

Decomposition:
- Add to mfp_ahb_const.vh: HTRANS_IDLE, HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, plus FSM state localparams (these may stay local to the module).
- No sub-module; the FSM and the counter are inline (about 200 lines).

Test Plan:
- Zero-wait write: req addr=0xBF800000, data=0x000000A5, size=2 → HTRANS=2'b10 for exactly 1 cycle, then HWDATA=0xA5 in the next cycle; rsp_valid 3 cycles after acceptance with rsp_err=0.
- Wait-state read: addr=0x80000010; slave holds HREADY=0 for 3 data-phase cycles, then returns HRDATA=0xDEADBEEF → rsp_valid 6 cycles after acceptance, rsp_rdata=0xDEADBEEF.
- ERROR response: slave drives HRESP=1/HREADY=0, then HRESP=1/HREADY=1 → rsp_err=1, rsp_timeout=0, rsp_rdata=0; HTRANS stays IDLE after the address phase.
- Misaligned and illegal requests: size=2 addr=0x80000002, and size=3 → no NONSEQ on the bus; rsp_valid next cycle with rsp_err=1.
- Timeout: TIMEOUT_CYCLES=8, HREADY held 0 → rsp_err=1 and rsp_timeout=1 after 8 data-phase cycles; req_ready=1 in the same cycle.
- Reset mid-transfer: assert HRESETn=0 during the DATA state → HTRANS=IDLE and rsp_valid=0 asynchronously; no response after release; the next request completes normally.
